// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation and
// write-port encodings, sequencer states and the cycle-counter width.
package md_pkg;

    localparam int CNT_W = 5;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    localparam logic [1:0] MDW_NONE = 2'b00;
    localparam logic [1:0] MDW_HI   = 2'b01;
    localparam logic [1:0] MDW_LO   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MULT = 2'b01,
        DIV  = 2'b10
    } md_state_t;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath. Works on the latched operands and
// owns the signed/unsigned handling, the 0x80000000 / -1 overflow case and
// divide-by-zero detection. Result is packed as {hi, lo}.
module md_arith
    import md_pkg::*;
(
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        is_signed,
    input  logic [1:0]  op,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic        a_neg_s;
    logic        b_neg_s;
    logic [63:0] a_ext_s;
    logic [63:0] b_ext_s;
    logic [63:0] prod_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] divisor_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic        overflow_s;

    // Sign handling, product, magnitude division and result selection
    always_comb begin
        a_neg_s     = is_signed & op_a[31];
        b_neg_s     = is_signed & op_b[31];
        // Sign/zero extension to 64 bits makes one multiplier serve both forms
        a_ext_s     = {{32{a_neg_s}}, op_a};
        b_ext_s     = {{32{b_neg_s}}, op_b};
        prod_s      = a_ext_s * b_ext_s;
        // Divide magnitudes, then restore signs: quotient truncates toward
        // zero and the remainder takes the dividend's sign
        a_mag_s     = a_neg_s ? (32'd0 - op_a) : op_a;
        b_mag_s     = b_neg_s ? (32'd0 - op_b) : op_b;
        div_by_zero = (op_b == 32'd0);
        divisor_s   = div_by_zero ? 32'd1 : b_mag_s;
        q_mag_s     = a_mag_s / divisor_s;
        r_mag_s     = a_mag_s % divisor_s;
        quot_s      = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
        rem_s       = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;
        overflow_s  = is_signed && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
        case (op)
            MD_MULT: result = prod_s;
            MD_DIV: begin
                if (overflow_s) begin
                    result = {32'h0000_0000, 32'h8000_0000};
                end else begin
                    result = {rem_s, quot_s};
                end
            end
            default: result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_sequencer_chk.sv
// Simulation checker for md_sequencer: the ID/EX stall logic must never
// present Start or MDWrite while Busy is high. chk_en lets a bench mask
// deliberately injected violations.
module md_sequencer_chk
    import md_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       chk_en,
    input  logic       busy,
    input  logic       start,
    input  logic [1:0] mdwrite
);

    // Issue attempts while busy indicate broken stall logic upstream
    no_issue_while_busy: assert property (
        @(posedge clk) disable iff (!rst_n || !chk_en)
        !(busy && (start || (mdwrite != MDW_NONE)))
    ) else $error("md_sequencer: Start/MDWrite presented while Busy (stall logic bug)");

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the EX stage: captures operands on Start,
// holds Busy for a fixed number of cycles, then commits HI/LO.
// Also services mthi/mtlo while idle.
// Optional feature macro: MD_CANCEL_EN adds a Cancel input that aborts the
// in-flight operation (and blocks Start/MDWrite in the cycle it is raised).
module md_sequencer
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [1:0]  MDOp,
    input  logic        CalcuSigned,
    input  logic [1:0]  MDWrite,
    input  logic [31:0] RData1,
    input  logic [31:0] RData2,
`ifdef MD_CANCEL_EN
    input  logic        Cancel,
`endif
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_t          state_r;
    md_state_t          state_nxt_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic [31:0]        op_a_r;
    logic [31:0]        op_a_nxt_s;
    logic [31:0]        op_b_r;
    logic [31:0]        op_b_nxt_s;
    logic               signed_r;
    logic               signed_nxt_s;
    logic [31:0]        hi_r;
    logic [31:0]        hi_nxt_s;
    logic [31:0]        lo_r;
    logic [31:0]        lo_nxt_s;
    logic               busy_r;
    logic               busy_nxt_s;
    logic               cancel_s;
    logic [1:0]         arith_op_s;
    logic [63:0]        arith_result_s;
    logic               div_by_zero_s;

`ifdef MD_CANCEL_EN
    assign cancel_s = Cancel;
`else
    assign cancel_s = 1'b0;
`endif

    assign arith_op_s = (state_r == DIV) ? MD_DIV : MD_MULT;

    md_arith u_arith (
        .op_a        (op_a_r),
        .op_b        (op_b_r),
        .is_signed   (signed_r),
        .op          (arith_op_s),
        .result      (arith_result_s),
        .div_by_zero (div_by_zero_s)
    );

    // Next-state, operand capture, count and HI/LO update decisions
    always_comb begin
        state_nxt_s  = state_r;
        count_nxt_s  = count_r;
        op_a_nxt_s   = op_a_r;
        op_b_nxt_s   = op_b_r;
        signed_nxt_s = signed_r;
        hi_nxt_s     = hi_r;
        lo_nxt_s     = lo_r;
        case (state_r)
            IDLE: begin
                if (cancel_s) begin
                    state_nxt_s = IDLE;
                end else if (Start) begin
                    // Start has priority over MDWrite; unknown MDOp is a no-op
                    case (MDOp)
                        MD_MULT: begin
                            state_nxt_s  = MULT;
                            count_nxt_s  = CNT_W'(MULT_CYCLES - 1);
                            op_a_nxt_s   = RData1;
                            op_b_nxt_s   = RData2;
                            signed_nxt_s = CalcuSigned;
                        end
                        MD_DIV: begin
                            state_nxt_s  = DIV;
                            count_nxt_s  = CNT_W'(DIV_CYCLES - 1);
                            op_a_nxt_s   = RData1;
                            op_b_nxt_s   = RData2;
                            signed_nxt_s = CalcuSigned;
                        end
                        default: state_nxt_s = IDLE;
                    endcase
                end else begin
                    case (MDWrite)
                        MDW_HI:  hi_nxt_s = RData1;
                        MDW_LO:  lo_nxt_s = RData1;
                        default: hi_nxt_s = hi_r;
                    endcase
                end
            end
            MULT, DIV: begin
                if (cancel_s) begin
                    state_nxt_s = IDLE;
                end else if (count_r == CNT_W'(0)) begin
                    state_nxt_s = IDLE;
                    // Divide by zero completes without touching HI/LO
                    if ((state_r == MULT) || !div_by_zero_s) begin
                        hi_nxt_s = arith_result_s[63:32];
                        lo_nxt_s = arith_result_s[31:0];
                    end else begin
                        hi_nxt_s = hi_r;
                    end
                end else begin
                    count_nxt_s = count_r - CNT_W'(1);
                end
            end
            default: state_nxt_s = IDLE;
        endcase
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // Sequencer state, operand latches and architectural HI/LO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            count_r  <= CNT_W'(0);
            op_a_r   <= 32'd0;
            op_b_r   <= 32'd0;
            signed_r <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            count_r  <= count_nxt_s;
            op_a_r   <= op_a_nxt_s;
            op_b_r   <= op_b_nxt_s;
            signed_r <= signed_nxt_s;
            hi_r     <= hi_nxt_s;
            lo_r     <= lo_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    assign Busy = busy_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule
